// File: rtl/stack_arbiter_pkg.sv
// stack_arbiter_pkg: shared sizing, FSM state encoding and push/pop op
// encoding for the data-stack controller.
package stack_arbiter_pkg;
    localparam int DEPTH = 256;   // stack entries; 8-bit pointer
    localparam int WIDTH = 8;     // data word width
    localparam int PTR_W = 8;
    localparam int CNT_W = 9;     // occupancy 0..DEPTH needs one extra bit

    localparam logic PUSH = 1'b1;
    localparam logic POP  = 1'b0;

    typedef enum logic {
        IDLE     = 1'b0,
        POP_WAIT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   valid    : request lines, bit N = port N
//   enable   : arbitration allowed this cycle
//   grant    : one-hot (or zero) grant, combinational
// The last-grant register resets to 1 so port 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    logic last;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (|grant)
            last <= grant[1];
    end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: controller for the 256x8 data stack RAM shared by the ALU
// (port 0) and the call/return unit (port 1). Owns sp and occupancy, grants
// one op per cycle round-robin, drives the RAM and returns pop data one
// cycle after the grant.
//   clk, rst                 : clock, synchronous active-high reset
//   reqN_valid/push/data     : request (push=1, pop=0), held until ready
//   reqN_ready               : request accepted this cycle
//   rspN_valid/data/err      : one-cycle response pulse
//   ram_addr/we/wdata/rdata  : RAM side; rdata valid the cycle after addr
//   sp, count, full, empty   : stack status
// Optional macro STACK_ARBITER_GUARD_EN: reject push-when-full and
// pop-when-empty with rspN_err instead of wrapping the pointer.
import stack_arbiter_pkg::*;

module stack_arbiter (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic             req0_push,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_push,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_err,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_err,
    output logic [PTR_W-1:0] ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [PTR_W-1:0] sp,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    state_t           state;
    logic [1:0]       grant;
    logic             gnt_any, gnt_port, gnt_push;
    logic [WIDTH-1:0] gnt_data;
    logic             reject, do_push, do_pop;
    logic             rsp_vld_q, rsp_port_q, rsp_err_q, rsp_hit;

    // No grants while in reset or while a pop is waiting for RAM data.
    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .enable (state == IDLE && !rst),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign gnt_any    = |grant;
    assign gnt_port   = grant[1];
    assign gnt_push   = gnt_port ? req1_push : req0_push;
    assign gnt_data   = gnt_port ? req1_data : req0_data;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

`ifdef STACK_ARBITER_GUARD_EN
    assign reject = gnt_any && (gnt_push == PUSH ? full : empty);
`else
    assign reject = 1'b0;
`endif

    assign do_push = gnt_any && gnt_push == PUSH && !reject;
    assign do_pop  = gnt_any && gnt_push == POP  && !reject;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (do_push) begin
            ram_addr  = sp;
            ram_we    = 1'b1;
            ram_wdata = gnt_data;
        end else if (do_pop) begin
            ram_addr  = sp - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sp         <= '0;
            count      <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_port_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            rsp_vld_q  <= gnt_any;
            rsp_port_q <= gnt_port;
            rsp_err_q  <= reject;
            case (state)
                IDLE: begin
                    if (do_push) begin
                        sp <= sp + 1'b1;
                        if (!full) count <= count + 1'b1;
                    end else if (do_pop) begin
                        sp    <= sp - 1'b1;
                        if (!empty) count <= count - 1'b1;
                        state <= POP_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response is masked during reset so a reset landing in POP_WAIT emits
    // no pulse. Pop data passes straight through from the RAM read port.
    assign rsp_hit    = rsp_vld_q && !rst;
    assign rsp0_valid = rsp_hit && !rsp_port_q;
    assign rsp1_valid = rsp_hit &&  rsp_port_q;
    assign rsp0_data  = (rsp0_valid && state == POP_WAIT) ? ram_rdata : '0;
    assign rsp1_data  = (rsp1_valid && state == POP_WAIT) ? ram_rdata : '0;

`ifdef STACK_ARBITER_GUARD_EN
    assign rsp0_err = rsp0_valid && rsp_err_q;
    assign rsp1_err = rsp1_valid && rsp_err_q;
`else
    assign rsp0_err = 1'b0;
    assign rsp1_err = 1'b0;
`endif
endmodule
